ghash_64: RTL and testbench
===========================

Name: ghash_64

Overview:
- Authentication stage directly downstream of GCTR_64 in the 64-bit GCM datapath.
- Consumes the 64-bit ciphertext blocks that GCTR_64 produces and folds them into a running hash, Y_i = (Y_{i-1} XOR X_i) • H, over GF(2^64).
- H is the hash subkey, E_K(0^64), loaded once per key.
- Uses a bit-serial multiplier (64 cycles per block) and emits the hash value as the tag at the last block of a message.

Parameters:
- WIDTH, 64, block and field width; only 64 is supported.
- POLY, 64'h000000000000001B, low-order terms of the reduction polynomial x^64 + x^4 + x^3 + x + 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- h_load  input  1  load strobe for the hash subkey.
- h_in  input  64  hash subkey value.
- in_valid  input  1  a ciphertext block is presented.
- in_data  input  64  ciphertext block from GCTR_64.
- in_last  input  1  the presented block is the final block of the message.
- in_ready  output  1  block can be accepted this cycle.
- tag_out  output  64  final hash value.
- tag_valid  output  1  one-cycle pulse; tag_out is valid.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low.
- Reset values: state=IDLE; H, Y, A, Z, tag_out all 0; count=0; tag_valid=0; last_q=0. in_ready=1 once reset deasserts.
- Bit convention: bit i of a 64-bit word is the coefficient of x^i. This is plain polynomial order, not GCM bit-reflected.
- States:
  - IDLE: in_ready = !h_load.
  - h_load=1 in IDLE: H <= h_in. No block is accepted that cycle; h_load has priority over in_valid.
  - Accept when in_valid && in_ready: A <= Y ^ in_data, Z <= 0, count <= 63, last_q <= in_last, go to MUL.
  - MUL: 64 cycles. Each cycle:
    - Z <= (Z<<1) ^ (Z[63] ? POLY : 0) ^ (A[count] ? H : 0).
    - count decrements.
    - This is MSB-first Horner evaluation.
    - On the cycle with count==0: Y <= final Z, go to IDLE.
    - If last_q: tag_out <= final Z, tag_valid <= 1 for exactly one cycle, Y <= 0 for the next message.
- in_ready=0 throughout MUL. h_load during MUL is ignored; H cannot change mid-multiply.
- Timing:
  - Accept at edge T0; multiply steps at edges T1..T64; Y and tag update at T64.
  - tag_valid is high in the cycle following T64.
  - in_ready is high again in the cycle following T64, so the next accept is at T65 at the earliest.
  - Throughput is one block per 65 cycles.
- tag_out holds its value until the next tag. tag_valid is a one-cycle pulse, no handshake; the consumer must capture it.
- in_data, in_last and in_valid are sampled only at the accept edge. Later changes have no effect.
- A single-block message (in_last on the first block) is legal.
- Reset asserted mid-MUL aborts immediately: Y and H are cleared, so H must be reloaded. No tag is emitted.
- No overflow or underflow is possible: upstream stalls on in_ready=0.

Decomposition:
- Package ghash_pkg holds:
  - WIDTH=64 and GHASH_POLY=64'h1B;
  - the state encoding (IDLE, MUL);
  - CNT_W=6.
- Sub-module gf64_mul_serial holds the bit-serial multiplier:
  - inputs: start, a, h;
  - outputs: busy, done, z;
  - it contains the count, A, and Z registers.
- ghash_64 holds the handshake, H/Y/tag registers, and last_q.

Test Plan:
- Reset, then h_load with h_in=64'h1; one block in_data=64'hDEADBEEF01234567 with in_last=1 -> tag_valid pulses exactly 65 cycles after accept; tag_out=64'hDEADBEEF01234567; in_ready low for 64 cycles, then high.
- h_in=64'h2; block 64'h8000000000000000 with in_last=1 -> tag_out=64'h000000000000001B (reduction path). Block 64'h0000000000000003 with in_last=1 -> tag_out=64'h6.
- h_in=64'h1; blocks 64'h1 (in_last=0) then 64'h1 (in_last=1) -> no tag after block 1; tag_out=64'h0 after block 2. A next message, block 64'h5 with in_last=1 -> tag_out=64'h5 (Y cleared after a tag).
- In IDLE, assert h_load=1 (h_in=64'h2) and in_valid=1 in the same cycle -> in_ready=0 and no accept. The next cycle accepts 64'h4 with in_last=1 -> tag_out=64'h8 (new H used). Pulsing h_load=64'h1 during MUL is ignored.
- Assert reset low at cycle 30 of MUL -> tag_valid stays 0 and tag_out=0. After h_load 64'h1 and block 64'h7 with in_last=1 -> tag_out=64'h7.
- Hold in_valid=1 continuously with 3 blocks (in_last on the 3rd) -> exactly 3 accepts, 65 cycles apart; one tag_valid pulse.

Source files
------------

// File: rtl/ghash_pkg.sv
// Shared constants and state encoding for the 64-bit GHASH stage.
package ghash_pkg;
  localparam int WIDTH = 64;
  localparam int CNT_W = 6;
  localparam logic [WIDTH-1:0] GHASH_POLY = 64'h000000000000001B;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;
endpackage

// File: rtl/gf64_mul_serial.sv
// Bit-serial GF(2^64) multiplier: MSB-first Horner evaluation, one bit of a per clock.
module gf64_mul_serial
  import ghash_pkg::*;
#(
  parameter logic [WIDTH-1:0] POLY = GHASH_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] h,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z
);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] z_nxt;

  // z is the look-ahead product so the caller can capture it on the final step edge
  always_comb begin
    z_nxt = {z_q[WIDTH-2:0], 1'b0} ^ (z_q[WIDTH-1] ? POLY : '0) ^ (a_q[count] ? h : '0);
    done  = busy && (count == '0);
    z     = z_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      a_q   <= '0;
      z_q   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      count <= CNT_W'(WIDTH - 1);
      a_q   <= a;
      z_q   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      z_q   <= z_nxt;
      count <= count - CNT_W'(1);
      if (count == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ghash_64.sv
// GHASH over GF(2^64): folds ciphertext blocks into Y = (Y ^ X) * H and emits a tag per message.
module ghash_64 #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] POLY  = ghash_pkg::GHASH_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             h_load,
  input  logic [WIDTH-1:0] h_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] tag_out,
  output logic             tag_valid
);
  import ghash_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             busy;
  logic             done;
  logic             last_q;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_fin;

  // h_load wins over a block in the same cycle, so H is stable for the whole multiply
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !h_load && !busy;
        accept   = in_valid && in_ready;
        if (accept) state_nxt = MUL;
      end
      MUL: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q       <= '0;
      y_q       <= '0;
      last_q    <= 1'b0;
      tag_out   <= '0;
      tag_valid <= 1'b0;
    end else begin
      tag_valid <= 1'b0;
      if (state == IDLE && h_load) h_q <= h_in;
      if (accept) last_q <= in_last;
      if (done) begin
        if (last_q) begin
          tag_out   <= z_fin;
          tag_valid <= 1'b1;
          y_q       <= '0;
        end else begin
          y_q <= z_fin;
        end
      end
    end
  end

  gf64_mul_serial #(
    .POLY(POLY)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .a     (y_q ^ in_data),
    .h     (h_q),
    .busy  (busy),
    .done  (done),
    .z     (z_fin)
  );

endmodule

// File: tb/tb_ghash_64.sv
// Directed bench for ghash_64 with a tag scoreboard and an independent GF(2^64) model.
module tb_ghash_64;

  logic        clk;
  logic        reset;
  logic        h_load;
  logic [63:0] h_in;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [63:0] tag_out;
  logic        tag_valid;

  typedef struct {
    logic [63:0] tag;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc0, acc1, acc2, lows;
  logic [63:0] m, d0, d1, d2;

  ghash_64 dut (
    .clk      (clk),
    .reset    (reset),
    .h_load   (h_load),
    .h_in     (h_in),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tag_out  (tag_out),
    .tag_valid(tag_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Carry-less product followed by top-down reduction by x^64 + x^4 + x^3 + x + 1
  function automatic logic [63:0] gf_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 64; i++)
      if (b[i]) p = p ^ ({64'h0, a} << i);
    for (int i = 127; i >= 64; i--)
      if (p[i]) p[i-64 +: 65] = p[i-64 +: 65] ^ 65'h1_0000_0000_0000_001B;
    return p[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tag_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_tag", {63'b0, tag_valid}, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tag_out", tag_out, e.tag);
        chk("tag_latency", 64'(cyc - e.acc), 64'd65);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic present(input logic [63:0] d, input logic l, input bit push,
                         input logic [63:0] e, output int acc);
    exp_t x;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc      = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      chk("ready_timeout", {63'b0, in_ready}, 64'h1);
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) begin
        x.tag = e;
        x.acc = acc;
        sb.push_back(x);
      end
    end
  endtask

  task automatic wait_tags();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("tag_pending", 64'(sb.size()), 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_h(input logic [63:0] v);
    h_load = 1'b1;
    h_in   = v;
    @(posedge clk);
    #1;
    h_load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; h_load = 1'b0; h_in = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {63'b0, in_ready}, 64'h1);
    chk("reset_tag_valid", {63'b0, tag_valid}, 64'h0);
    chk("reset_tag_out", tag_out, 64'h0);
    @(posedge clk);
    #1;

    // Identity key, single-block message; in_ready low for the whole multiply
    load_h(64'h1);
    present(64'hDEADBEEF01234567, 1'b1, 1'b1, 64'hDEADBEEF01234567, acc0);
    lows = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready === 1'b0) lows++;
    end
    chk("ready_low_cycles", 64'(lows), 64'd64);
    @(negedge clk);
    chk("ready_high_after", {63'b0, in_ready}, 64'h1);
    wait_tags();

    // Reduction path and a small product
    load_h(64'h2);
    present(64'h8000000000000000, 1'b1, 1'b1, 64'h000000000000001B, acc0);
    wait_tags();
    present(64'h3, 1'b1, 1'b1, 64'h6, acc0);
    wait_tags();

    // Chaining through Y, then Y cleared after a tag
    load_h(64'h1);
    present(64'h1, 1'b0, 1'b0, 64'h0, acc0);
    present(64'h1, 1'b1, 1'b1, 64'h0, acc0);
    wait_tags();
    present(64'h5, 1'b1, 1'b1, 64'h5, acc0);
    wait_tags();

    // h_load beats in_valid; h_load during the multiply is ignored
    h_load = 1'b1; h_in = 64'h2;
    in_valid = 1'b1; in_data = 64'h4; in_last = 1'b1;
    @(negedge clk);
    chk("ready_during_hload", {63'b0, in_ready}, 64'h0);
    @(posedge clk);
    #1 h_load = 1'b0;
    present(64'h4, 1'b1, 1'b1, 64'h8, acc0);
    repeat (10) @(posedge clk);
    #1 h_load = 1'b1; h_in = 64'h1;
    @(posedge clk);
    #1 h_load = 1'b0;
    wait_tags();

    // Reset in the middle of a multiply aborts it and clears Y and H
    present(64'h9, 1'b0, 1'b0, 64'h0, acc0);
    present(64'h3, 1'b1, 1'b0, 64'h0, acc0);
    repeat (30) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_tag_valid", {63'b0, tag_valid}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (80) @(negedge clk);
    chk("abort_tag_out", tag_out, 64'h0);
    chk("abort_in_ready", {63'b0, in_ready}, 64'h1);
    @(posedge clk);
    #1;
    load_h(64'h1);
    present(64'h7, 1'b1, 1'b1, 64'h7, acc0);
    wait_tags();

    // Back-to-back three-block message with in_valid held high
    load_h(64'h3);
    d0 = 64'h0123456789ABCDEF;
    d1 = 64'hF0E1D2C3B4A59687;
    d2 = 64'h8000000000000001;
    m  = gf_mul(d0, 64'h3);
    m  = gf_mul(m ^ d1, 64'h3);
    m  = gf_mul(m ^ d2, 64'h3);
    present(d0, 1'b0, 1'b0, 64'h0, acc0);
    present(d1, 1'b0, 1'b0, 64'h0, acc1);
    present(d2, 1'b1, 1'b1, m, acc2);
    chk("b2b_gap1", 64'(acc1 - acc0), 64'd65);
    chk("b2b_gap2", 64'(acc2 - acc1), 64'd65);
    wait_tags();
    repeat (70) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
